// File: rtl/of_stage_fwd_if.sv
// Decode-to-OF-to-EX handshake and operand bus, plus the forwarding and write-back taps.
interface of_stage_fwd_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] pc;
  logic            is_st;
  logic            is_ret;
  logic            flush;
  logic            wb_en;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            ex_fwd_en;
  logic            ex_is_ld;
  logic [4:0]      ex_rd;
  logic [XLEN-1:0] ex_data;
  logic            ma_fwd_en;
  logic [4:0]      ma_rd;
  logic [XLEN-1:0] ma_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [XLEN-1:0] immx;
  logic [XLEN-1:0] branch_target;
  logic [5:0]      opcode_i;
  logic [4:0]      out_rd;

  modport master (
    output in_valid, inst, pc, is_st, is_ret, flush,
           wb_en, wb_addr, wb_data,
           ex_fwd_en, ex_is_ld, ex_rd, ex_data,
           ma_fwd_en, ma_rd, ma_data, out_ready,
    input  in_ready, out_valid, op1, op2, immx, branch_target, opcode_i, out_rd
  );

  modport slave (
    input  in_valid, inst, pc, is_st, is_ret, flush,
           wb_en, wb_addr, wb_data,
           ex_fwd_en, ex_is_ld, ex_rd, ex_data,
           ma_fwd_en, ma_rd, ma_data, out_ready,
    output in_ready, out_valid, op1, op2, immx, branch_target, opcode_i, out_rd
  );
endinterface

// File: rtl/of_stage_fwd.sv
// Operand-fetch stage: register file, EX/MA/WB forwarding, load-use stall, registered EX bundle.
module of_stage_fwd #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NREG    = 32,
  parameter int unsigned RA_IDX  = NREG - 1,
  parameter bit          ZERO_R0 = 1'b0
) (
  input logic         clk,
  input logic         rst,
  of_stage_fwd_if.slave bus
);
  localparam int unsigned IW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [XLEN-1:0] rf [NREG];
  logic [IW-1:0]   s1, s2, ex_i, ma_i, wb_i;
  logic [XLEN-1:0] opnd1, opnd2;
  logic            hazard, accept, ready_c;
  logic signed [15:0] imm_s;
  logic signed [26:0] off_s;

  logic            out_valid_q;
  logic [XLEN-1:0] op1_q, op2_q, immx_q, bt_q;
  logic [5:0]      opcode_i_q;
  logic [4:0]      out_rd_q;

  // Highest-priority source for one operand index.
  function automatic logic [XLEN-1:0] pick(
    input logic [IW-1:0] idx, input logic [XLEN-1:0] rfv,
    input logic exf, input logic exl, input logic [IW-1:0] exi, input logic [XLEN-1:0] exd,
    input logic maf, input logic [IW-1:0] mai, input logic [XLEN-1:0] mad,
    input logic wbe, input logic [IW-1:0] wbi, input logic [XLEN-1:0] wbd);
    if (ZERO_R0 && idx == '0)           return '0;
    else if (exf && !exl && exi == idx) return exd;
    else if (maf && mai == idx)         return mad;
    else if (wbe && wbi == idx)         return wbd;
    else                                return rfv;
  endfunction

  // A load in EX targeting this index cannot be forwarded yet.
  function automatic logic ld_hit(input logic [IW-1:0] idx, input logic exf,
                                  input logic exl, input logic [IW-1:0] exi);
    return exf && exl && exi == idx && !(ZERO_R0 && idx == '0);
  endfunction

  assign s1   = bus.is_ret ? IW'(RA_IDX) : IW'(bus.inst[20:16]);
  assign s2   = bus.is_st ? IW'(bus.inst[25:21]) : IW'(bus.inst[15:11]);
  assign ex_i = IW'(bus.ex_rd);
  assign ma_i = IW'(bus.ma_rd);
  assign wb_i = IW'(bus.wb_addr);

  assign imm_s = bus.inst[15:0];
  assign off_s = bus.inst[26:0];

  // Operand resolution and handshake decision.
  always_comb begin
    opnd1  = pick(s1, rf[s1], bus.ex_fwd_en, bus.ex_is_ld, ex_i, bus.ex_data,
                  bus.ma_fwd_en, ma_i, bus.ma_data, bus.wb_en, wb_i, bus.wb_data);
    opnd2  = pick(s2, rf[s2], bus.ex_fwd_en, bus.ex_is_ld, ex_i, bus.ex_data,
                  bus.ma_fwd_en, ma_i, bus.ma_data, bus.wb_en, wb_i, bus.wb_data);
    hazard = ld_hit(s1, bus.ex_fwd_en, bus.ex_is_ld, ex_i) ||
             ld_hit(s2, bus.ex_fwd_en, bus.ex_is_ld, ex_i);
    ready_c = !hazard && (!out_valid_q || bus.out_ready);
    accept  = bus.in_valid && ready_c && !bus.flush;
  end

  assign bus.in_ready = ready_c;

  // Register file write port; writes land regardless of stall or flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) rf[IW'(i)] <= '0;
    end else if (bus.wb_en && !(ZERO_R0 && wb_i == '0)) begin
      rf[wb_i] <= bus.wb_data;
    end
  end

  // Output bundle: flush kills, accept loads, EX take drains, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      immx_q      <= '0;
      bt_q        <= '0;
      opcode_i_q  <= '0;
      out_rd_q    <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      op1_q       <= opnd1;
      op2_q       <= opnd2;
      immx_q      <= XLEN'(imm_s);
      bt_q        <= bus.pc + XLEN'(off_s);
      opcode_i_q  <= bus.inst[31:26];
      out_rd_q    <= bus.inst[25:21];
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.op1           = op1_q;
  assign bus.op2           = op2_q;
  assign bus.immx          = immx_q;
  assign bus.branch_target = bt_q;
  assign bus.opcode_i      = opcode_i_q;
  assign bus.out_rd        = out_rd_q;
endmodule

// File: doc/of_stage_fwd.md
Name: of_stage_fwd

Overview:
- Parametrised next-generation operand-fetch stage for the pipelined SimpleRISC core; sits between decode and execute.
- Owns the register file: 2 read ports, 1 write port.
- Resolves operands with write-back bypass and EX/MA forwarding, and detects load-use hazards (stalls upstream).
- Presents a registered, valid/ready-handshaked operand bundle to EX, replacing the strobe-driven RRF/WRF/DMop/UPC sequencing.

Parameters:
- XLEN, 32, datapath and register width (>=16).
- NREG, 32, number of architectural registers (power of 2, <=32).
- RA_IDX, NREG-1, register index forced as op1 source when is_ret.
- ZERO_R0, 0, 1 = r0 reads as 0 and ignores writes; 0 = r0 is a general register.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  decode holds a valid instruction
- in_ready  out  1  stage accepts instruction this cycle
- inst  in  32  instruction: opcode[31:27], I[26], rd[25:21], rs1[20:16], rs2[15:11], imm[15:0], off[26:0]
- pc  in  XLEN  instruction PC
- is_st  in  1  store: op2 source = rd field
- is_ret  in  1  return: op1 source = RA_IDX
- flush  in  1  kill output slot and any accepted instruction (branch taken)
- wb_en  in  1  write-back enable
- wb_addr  in  5  write-back register
- wb_data  in  XLEN  write-back data
- ex_fwd_en  in  1  EX result valid for forwarding
- ex_is_ld  in  1  instruction in EX is a load (data not yet available)
- ex_rd  in  5  EX destination
- ex_data  in  XLEN  EX result
- ma_fwd_en  in  1  MA result valid for forwarding
- ma_rd  in  5  MA destination
- ma_data  in  XLEN  MA result
- out_valid  out  1  operand bundle valid
- out_ready  in  1  EX accepts bundle
- op1  out  XLEN  resolved operand 1
- op2  out  XLEN  resolved operand 2
- immx  out  XLEN  sign-extended imm[15:0]
- branch_target  out  XLEN  pc + sign-extended off[26:0], mod 2^XLEN
- opcode_i  out  6  {opcode, I}
- out_rd  out  5  rd field passed down

Behaviour:
- Reset (async, immediate): out_valid=0; op1, op2, immx, branch_target, opcode_i, out_rd = 0; all NREG registers = 0; in_ready=1 once rst deasserts.
- Source select:
  - s1 = is_ret ? RA_IDX : rs1.
  - s2 = is_st ? rd : rs2.
  - Indices truncated to log2(NREG) bits.
- Operand priority per source, highest first:
  1. ZERO_R0 && idx==0 -> 0
  2. ex_fwd_en && !ex_is_ld && ex_rd==idx -> ex_data
  3. ma_fwd_en && ma_rd==idx -> ma_data
  4. wb_en && wb_addr==idx -> wb_data (same-cycle write-first bypass)
  5. register file
- Load-use hazard: ex_fwd_en && ex_is_ld && ex_rd matches s1 or s2 (after ZERO_R0 exclusion).
  - in_ready=0 for that cycle; bubble inserted (out_valid=0 next cycle if EX accepts).
  - Exactly one bubble per load-use; next cycle MA forwarding supplies the data.
- Output register (latency 1 cycle from accept):
  - Load when in_valid && in_ready.
  - in_ready = !hazard && (!out_valid || out_ready).
  - Output holds stable while out_valid && !out_ready.
  - If EX takes the bundle and nothing new is accepted, out_valid clears to 0.
- Held-bundle refresh: while stalled by out_ready=0, the held op1/op2 are not re-resolved. EX must retain forwarding data until it accepts.
- flush: next edge out_valid=0 and in_ready is ignored that cycle (no accept). flush has priority over accept and hazard.
- Register write:
  - Rising edge with wb_en writes wb_data to wb_addr, regardless of stall or flush.
  - Write to r0 dropped when ZERO_R0=1.
- Simultaneous EX, MA and WB hits on the same index: EX wins; on an EX load, MA wins with hazard still raised.
- Reset mid-stall: all state cleared, pending instruction discarded.

Test Plan:
- Reset, then wb_en writes r5=0x1234 at cycle 1; cycle 2 issue add with rs1=5 -> op1=0x1234 at cycle 3, out_valid=1.
- Same-cycle bypass: wb_en r7=0xAAAA5555 and an instruction reading rs2=7 in the same cycle -> op2=0xAAAA5555.
- Forward priority: EX r3=0x11, MA r3=0x22, WB r3=0x33, read r3 -> op1=0x11; drop ex_fwd_en -> op1=0x22.
- Load-use: ex_is_ld=1, ex_rd=4, instruction reads rs1=4 -> in_ready=0 for one cycle, bubble; next cycle ma_rd=4, ma_data=0x99 -> op1=0x99.
- Backpressure and flush: out_ready=0 for 3 cycles -> outputs stable and in_ready=0; then assert flush -> out_valid=0 next edge.
- Ret and branch: is_ret with r31=0x400 -> op1=0x400; pc=0x100, off=0x7FFFFFC (-4) -> branch_target=0xFC; ZERO_R0=1 write r0=5 -> r0 still reads 0.
